// File: rtl/joypad_i2c_poller_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : joypad_i2c_poller_pkg
//  Purpose  : Shared types and constants for the joypad I2C poller.
//  Revision : 1.0  initial release
// ============================================================================
package joypad_i2c_poller_pkg;

    // Transaction FSM states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        WBIT  = 3'd2,
        WACK  = 3'd3,
        RBIT  = 3'd4,
        RACK  = 3'd5,
        STOP  = 3'd6
    } state_t;

    // R/W bit appended to the 7-bit slave address
    localparam logic I2C_WRITE = 1'b0;
    localparam logic I2C_READ  = 1'b1;

    // Register pointer written before every read burst, and burst length
    localparam logic [7:0] JOYPAD_REG_PTR   = 8'h00;
    localparam int         JOYPAD_NUM_BYTES = 2;

    // Controller reports pressed as 0; the game core wants pressed as 1
    function automatic logic [15:0] pack_buttons(input logic [7:0] b0, input logic [7:0] b1);
        return {~b0, ~b1};
    endfunction

endpackage
`default_nettype wire

// File: rtl/joypad_i2c_poller_quarter_tick.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_quarter_tick
//  Purpose  : Divides clk down to one tick per SCL quarter-period. The count
//             is held at zero while disabled so every transaction starts
//             with a full-length first quarter.
//  Revision : 1.0  initial release
// ============================================================================
module i2c_quarter_tick #(
    parameter int QUARTER_DIV = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);
    localparam int            CW   = (QUARTER_DIV > 2) ? $clog2(QUARTER_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(QUARTER_DIV - 1);

    logic [CW-1:0] cnt;

    // Quarter counter: 0..QUARTER_DIV-1, cleared when disabled
    always_ff @(posedge clk) begin
        if (rst || !en)
            cnt <= '0;
        else if (cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

    assign tick = en && (cnt == LAST);

endmodule
`default_nettype wire

// File: rtl/joypad_i2c_poller.sv
`default_nettype none
// ============================================================================
//  Module   : joypad_i2c_poller
//  Purpose  : Periodic I2C master: writes register pointer 0x00 to the joypad
//             controller, then reads two bytes and publishes them inverted
//             as an active-high button word.
//  Revision : 1.0  initial release
// ============================================================================
module joypad_i2c_poller
    import joypad_i2c_poller_pkg::*;
#(
    parameter int         QUARTER_DIV = 5,
    parameter logic [6:0] DEV_ADDR    = 7'h52,
    parameter int         POLL_DIV    = 33333
) (
    input  logic        clk,
    input  logic        rst,
    output logic        scl_out,
    output logic        sda_out,
    input  logic        sda_in,
    output logic [15:0] buttons,
    output logic        valid,
    output logic        nack_err,
    output logic        busy
);
    localparam int               POLL_W    = $clog2(POLL_DIV);
    localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_DIV - 1);
    localparam logic             LAST_BYTE = 1'(JOYPAD_NUM_BYTES - 1);

    state_t            state, state_nxt;
    logic [1:0]        q, q_nxt;
    logic [2:0]        bit_cnt, bit_cnt_nxt;
    logic              byte_idx, byte_idx_nxt;
    logic              phase, phase_nxt;          // 0 = pointer write, 1 = read
    logic              wbyte, wbyte_nxt;          // 0 = address byte, 1 = pointer byte
    logic [7:0]        shreg, shreg_nxt;
    logic [7:0]        byte0, byte0_nxt;
    logic              sampled, sampled_nxt;
    logic              nack_flag, nack_flag_nxt;
    logic              pending, pending_nxt;
    logic [POLL_W-1:0] poll_cnt, poll_cnt_nxt;
    logic              scl_nxt, sda_nxt;
    logic [15:0]       buttons_nxt;
    logic              valid_nxt, nack_err_nxt, busy_nxt;
    logic              sda_meta, sda_sync;
    logic              tick, enter, poll_wrap, data_state;

    i2c_quarter_tick #(.QUARTER_DIV(QUARTER_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (state != IDLE),
        .tick (tick)
    );

    // Two-flop synchroniser for the asynchronous SDA pad
    always_ff @(posedge clk) begin
        if (rst) begin
            sda_meta <= 1'b1;
            sda_sync <= 1'b1;
        end else begin
            sda_meta <= sda_in;
            sda_sync <= sda_meta;
        end
    end

    // State and registered-output update
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            q         <= 2'd0;
            bit_cnt   <= 3'd0;
            byte_idx  <= 1'b0;
            phase     <= 1'b0;
            wbyte     <= 1'b0;
            shreg     <= 8'h00;
            byte0     <= 8'h00;
            sampled   <= 1'b1;
            nack_flag <= 1'b0;
            pending   <= 1'b0;
            poll_cnt  <= '0;
            scl_out   <= 1'b1;
            sda_out   <= 1'b1;
            buttons   <= 16'h0000;
            valid     <= 1'b0;
            nack_err  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            q         <= q_nxt;
            bit_cnt   <= bit_cnt_nxt;
            byte_idx  <= byte_idx_nxt;
            phase     <= phase_nxt;
            wbyte     <= wbyte_nxt;
            shreg     <= shreg_nxt;
            byte0     <= byte0_nxt;
            sampled   <= sampled_nxt;
            nack_flag <= nack_flag_nxt;
            pending   <= pending_nxt;
            poll_cnt  <= poll_cnt_nxt;
            scl_out   <= scl_nxt;
            sda_out   <= sda_nxt;
            buttons   <= buttons_nxt;
            valid     <= valid_nxt;
            nack_err  <= nack_err_nxt;
            busy      <= busy_nxt;
        end
    end

    // Next-state and bus-drive logic; quarter outputs are applied on entry
    always_comb begin
        state_nxt     = state;
        q_nxt         = q;
        bit_cnt_nxt   = bit_cnt;
        byte_idx_nxt  = byte_idx;
        phase_nxt     = phase;
        wbyte_nxt     = wbyte;
        shreg_nxt     = shreg;
        byte0_nxt     = byte0;
        sampled_nxt   = sampled;
        nack_flag_nxt = nack_flag;
        scl_nxt       = scl_out;
        sda_nxt       = sda_out;
        buttons_nxt   = buttons;
        valid_nxt     = 1'b0;
        nack_err_nxt  = nack_err;
        busy_nxt      = busy;
        enter         = 1'b0;

        poll_wrap    = (poll_cnt == POLL_LAST);
        poll_cnt_nxt = poll_wrap ? '0 : poll_cnt + POLL_W'(1);
        pending_nxt  = pending | poll_wrap;
        data_state   = (state == WBIT) || (state == WACK) || (state == RBIT) || (state == RACK);

        if (state == IDLE) begin
            if (pending) begin
                state_nxt     = START;
                q_nxt         = 2'd0;
                pending_nxt   = poll_wrap;
                phase_nxt     = 1'b0;
                nack_flag_nxt = 1'b0;
                busy_nxt      = 1'b1;
                enter         = 1'b1;
            end
        end else if (tick) begin
            if (q != 2'd3) begin
                q_nxt = q + 2'd1;
                case (q)
                    2'd0: begin
                        if (state == START) sda_nxt = 1'b0;
                        else                scl_nxt = 1'b1;
                    end
                    2'd1: begin
                        if (state == START)     scl_nxt = 1'b0;
                        else if (state == STOP) sda_nxt = 1'b1;
                        else                    sampled_nxt = sda_sync;
                    end
                    default: begin
                        if (data_state) scl_nxt = 1'b0;
                    end
                endcase
            end else begin
                q_nxt = 2'd0;
                enter = 1'b1;
                case (state)
                    START: begin
                        shreg_nxt    = {DEV_ADDR, (phase ? I2C_READ : I2C_WRITE)};
                        bit_cnt_nxt  = 3'd0;
                        wbyte_nxt    = 1'b0;
                        byte_idx_nxt = 1'b0;
                        state_nxt    = WBIT;
                    end
                    WBIT: begin
                        shreg_nxt   = {shreg[6:0], 1'b0};
                        bit_cnt_nxt = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state_nxt = WACK;
                    end
                    WACK: begin
                        if (sampled) begin
                            nack_flag_nxt = 1'b1;
                            state_nxt     = STOP;
                        end else if (!phase) begin
                            if (!wbyte) begin
                                shreg_nxt = JOYPAD_REG_PTR;
                                wbyte_nxt = 1'b1;
                                state_nxt = WBIT;
                            end else begin
                                state_nxt = STOP;
                            end
                        end else begin
                            state_nxt = RBIT;
                        end
                    end
                    RBIT: begin
                        shreg_nxt   = {shreg[6:0], sampled};
                        bit_cnt_nxt = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state_nxt = RACK;
                    end
                    RACK: begin
                        if (byte_idx != LAST_BYTE) begin
                            byte0_nxt    = shreg;
                            byte_idx_nxt = byte_idx + 1'b1;
                            state_nxt    = RBIT;
                        end else begin
                            state_nxt = STOP;
                        end
                    end
                    STOP: begin
                        if (nack_flag) begin
                            nack_err_nxt = 1'b1;
                            busy_nxt     = 1'b0;
                            state_nxt    = IDLE;
                        end else if (!phase) begin
                            phase_nxt = 1'b1;
                            state_nxt = START;
                        end else begin
                            buttons_nxt  = pack_buttons(byte0, shreg);
                            valid_nxt    = 1'b1;
                            nack_err_nxt = 1'b0;
                            busy_nxt     = 1'b0;
                            state_nxt    = IDLE;
                        end
                    end
                    default: state_nxt = IDLE;
                endcase
            end
        end

        // Quarter-0 drive of the state being entered
        if (enter) begin
            case (state_nxt)
                IDLE, START: begin scl_nxt = 1'b1; sda_nxt = 1'b1; end
                WBIT:        begin scl_nxt = 1'b0; sda_nxt = shreg_nxt[7]; end
                RACK:        begin scl_nxt = 1'b0; sda_nxt = (byte_idx == LAST_BYTE); end
                STOP:        begin scl_nxt = 1'b0; sda_nxt = 1'b0; end
                default:     begin scl_nxt = 1'b0; sda_nxt = 1'b1; end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_joypad_i2c_poller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_joypad_i2c_poller
//  Purpose  : Directed bench with a behavioural open-drain joypad slave on a
//             wired-AND bus.
//  Revision : 1.0  initial release
// ============================================================================
module tb_joypad_i2c_poller;
    localparam int         QD   = 5;
    localparam int         PD   = 1500;
    localparam logic [6:0] DEV  = 7'h52;

    logic        clk;
    logic        rst;
    logic        scl_out, sda_out, sda_in;
    logic [15:0] buttons;
    logic        valid, nack_err, busy;

    // Slave-side state
    logic        slave_sda = 1'b1;
    logic        present   = 1'b1;
    logic [7:0]  tx0 = 8'hFF, tx1 = 8'hFF;
    logic        sda_bus;

    assign sda_bus = sda_out & slave_sda;
    assign sda_in  = sda_bus;

    joypad_i2c_poller #(.QUARTER_DIV(QD), .DEV_ADDR(DEV), .POLL_DIV(PD)) dut (
        .clk(clk), .rst(rst), .scl_out(scl_out), .sda_out(sda_out), .sda_in(sda_in),
        .buttons(buttons), .valid(valid), .nack_err(nack_err), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    initial forever begin @(posedge clk); cyc++; end

    // Monitor and slave, evaluated between clock edges
    int         activity = 0, valid_cnt = 0, sda_hi_cnt = 0, scl_period = 0;
    int         nw = 0, nm = 0;
    logic [7:0] wlog  [0:63];
    logic       macks [0:63];
    initial begin
        logic p_scl, p_sda, p_so, p_do, s_active, addressed, rw;
        logic [7:0] rx, cur;
        int fbit, byte_no, rise_idx, t_rise;
        p_scl = 1'b1; p_sda = 1'b1; p_so = 1'b1; p_do = 1'b1;
        s_active = 1'b0; addressed = 1'b0; rw = 1'b0; rx = 8'h00; cur = 8'h00;
        fbit = 0; byte_no = 0; rise_idx = 0; t_rise = 0;
        forever begin
            @(negedge clk);
            if (scl_out !== p_so || sda_out !== p_do) activity++;
            if (valid === 1'b1) valid_cnt++;
            if (rst) begin
                s_active  = 1'b0;
                slave_sda = 1'b1;
            end else if (p_scl && scl_out && p_sda && !sda_bus) begin
                sda_hi_cnt++;
                s_active = 1'b1; fbit = -1; byte_no = 0; addressed = 1'b0;
                rw = 1'b0; slave_sda = 1'b1; rise_idx = 0;
            end else if (p_scl && scl_out && !p_sda && sda_bus) begin
                sda_hi_cnt++;
                s_active  = 1'b0;
                slave_sda = 1'b1;
            end else if (s_active) begin
                if (!p_scl && scl_out) begin
                    if (rise_idx == 0) t_rise = cyc;
                    else if (rise_idx == 1) scl_period = cyc - t_rise;
                    rise_idx++;
                    if (fbit >= 0 && fbit < 8 && !(addressed && rw)) rx = {rx[6:0], sda_bus};
                    if (fbit == 8 && addressed && rw && byte_no >= 1 && nm < 64) begin
                        macks[nm] = sda_bus; nm++;
                    end
                end else if (p_scl && !scl_out) begin
                    fbit++;
                    if (fbit == 9) begin fbit = 0; byte_no++; end
                    slave_sda = 1'b1;
                    if (fbit == 8 && !(addressed && rw)) begin
                        if (byte_no == 0) begin
                            addressed = present && (rx[7:1] == DEV);
                            rw        = rx[0];
                        end
                        if (nw < 64) begin wlog[nw] = rx; nw++; end
                        if (addressed) slave_sda = 1'b0;
                    end else if (fbit < 8 && addressed && rw && byte_no >= 1 && byte_no <= 2) begin
                        cur       = (byte_no == 1) ? tx0 : tx1;
                        slave_sda = cur[7-fbit];
                    end
                end
            end
            p_scl = scl_out; p_sda = sda_bus; p_so = scl_out; p_do = sda_out;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait for a poll to start and finish, with bounded waits
    task automatic wait_txn(output logic ok);
        int n;
        ok = 1'b0;
        n  = 0;
        while (busy !== 1'b1 && n < 2 * PD) begin @(posedge clk); #1; n++; end
        if (busy === 1'b1) begin
            n = 0;
            while (busy !== 1'b0 && n < 2000) begin @(posedge clk); #1; n++; end
            ok = (busy === 1'b0);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        logic ok;
        int   abase, wbase, mbase, vbase, hbase, n;

        // 1: reset state and quiet bus until the first poll
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("rst_scl", {31'd0, scl_out}, 32'd1);
        check("rst_sda", {31'd0, sda_out}, 32'd1);
        check("rst_buttons", {16'd0, buttons}, 32'd0);
        check("rst_flags", {29'd0, valid, nack_err, busy}, 32'd0);
        rst   = 1'b0;
        abase = activity;
        repeat (PD - 10) @(posedge clk);
        #1;
        check("idle_activity", activity - abase, 32'd0);
        check("idle_busy", {31'd0, busy}, 32'd0);

        // 2: normal poll, slave returns 0xFE, 0x7F
        present = 1'b1; tx0 = 8'hFE; tx1 = 8'h7F;
        wbase = nw; mbase = nm; vbase = valid_cnt; hbase = sda_hi_cnt;
        wait_txn(ok);
        check("t2_done", {31'd0, ok}, 32'd1);
        check("t2_nbytes", nw - wbase, 32'd3);
        check("t2_addr_w", {24'd0, wlog[wbase]}, 32'hA4);
        check("t2_ptr", {24'd0, wlog[wbase+1]}, 32'h00);
        check("t2_addr_r", {24'd0, wlog[wbase+2]}, 32'hA5);
        check("t2_mack0", {31'd0, macks[mbase]}, 32'd0);
        check("t2_mack1", {31'd0, macks[mbase+1]}, 32'd1);
        check("t2_buttons", {16'd0, buttons}, 32'h0180);
        check("t2_valid", valid_cnt - vbase, 32'd1);
        check("t2_nack", {31'd0, nack_err}, 32'd0);
        check("t2_sda_hi_chg", sda_hi_cnt - hbase, 32'd4);
        check("t2_scl_period", scl_period, 4 * QD);

        // 3: slave absent
        present = 1'b0;
        wbase = nw; vbase = valid_cnt; hbase = sda_hi_cnt;
        wait_txn(ok);
        check("t3_done", {31'd0, ok}, 32'd1);
        check("t3_nbytes", nw - wbase, 32'd1);
        check("t3_nack", {31'd0, nack_err}, 32'd1);
        check("t3_valid", valid_cnt - vbase, 32'd0);
        check("t3_buttons", {16'd0, buttons}, 32'h0180);
        check("t3_sda_hi_chg", sda_hi_cnt - hbase, 32'd2);

        // 4: recovery after NACK
        present = 1'b1; tx0 = 8'h00; tx1 = 8'h00;
        vbase = valid_cnt;
        wait_txn(ok);
        check("t4_done", {31'd0, ok}, 32'd1);
        check("t4_nack", {31'd0, nack_err}, 32'd0);
        check("t4_buttons", {16'd0, buttons}, 32'hFFFF);
        check("t4_valid", valid_cnt - vbase, 32'd1);

        // 5: reset during the first read byte
        tx0 = 8'h5A; tx1 = 8'h3C;
        wbase = nw;
        n = 0;
        while (nw < wbase + 3 && n < 3 * PD) begin @(posedge clk); #1; n++; end
        check("t5_reached_read", {31'd0, (nw >= wbase + 3)}, 32'd1);
        repeat (40) @(posedge clk);
        #1;
        check("t5_busy_before", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("t5_scl", {31'd0, scl_out}, 32'd1);
        check("t5_sda", {31'd0, sda_out}, 32'd1);
        check("t5_busy", {31'd0, busy}, 32'd0);
        check("t5_buttons", {16'd0, buttons}, 32'd0);
        rst   = 1'b0;
        vbase = valid_cnt;
        wait_txn(ok);
        check("t5_done", {31'd0, ok}, 32'd1);
        check("t5_buttons_after", {16'd0, buttons}, 32'hA5C3);
        check("t5_valid", valid_cnt - vbase, 32'd1);
        check("t5_nack", {31'd0, nack_err}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
